display_multiplexado: RTL

Parametrised N-digit, time-multiplexed 7-segment display driver. It scans one digit at a time with active-low anodes and active-low segments. Each scan includes a short blanking gap between digits to prevent ghosting. Features: double-buffered value loading (tear-free), optional hex glyphs, leading-zero suppression, and per-digit decimal points. It sits between the datapath/FSM and the board display pins.

---
 rtl/display_multiplexado_pkg.sv | 29 ++
 rtl/display_multiplexado_decodificador_hex.sv | 43 ++++
 rtl/display_multiplexado.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/display_multiplexado_pkg.sv
// Shared constants for the multiplexed 7-segment display driver:
// scan-state encoding, blank pattern and active-low glyphs (a..g).
package display_multiplexado_pkg;

    typedef enum logic {
        EXIBE   = 1'b0,
        APAGADO = 1'b1
    } estado_t;

    localparam logic [0:6] SEG_APAGADO = 7'b1111111;

    localparam logic [0:6] G_0 = 7'b0000001;
    localparam logic [0:6] G_1 = 7'b1001111;
    localparam logic [0:6] G_2 = 7'b0010010;
    localparam logic [0:6] G_3 = 7'b0000110;
    localparam logic [0:6] G_4 = 7'b1001100;
    localparam logic [0:6] G_5 = 7'b0100100;
    localparam logic [0:6] G_6 = 7'b0100000;
    localparam logic [0:6] G_7 = 7'b0001111;
    localparam logic [0:6] G_8 = 7'b0000000;
    localparam logic [0:6] G_9 = 7'b0000100;
    localparam logic [0:6] G_A = 7'b0001000;
    localparam logic [0:6] G_B = 7'b1100000;
    localparam logic [0:6] G_C = 7'b0110001;
    localparam logic [0:6] G_D = 7'b1000010;
    localparam logic [0:6] G_E = 7'b0110000;
    localparam logic [0:6] G_F = 7'b0111000;

endpackage

// File: rtl/display_multiplexado_decodificador_hex.sv
// Combinational nibble-to-glyph decoder, active-low segments a..g.
// Ports: valor (4b), modo_hex (show A..F), apagar (force blank) -> segmentos[0:6].
module decodificador_hex
    import display_multiplexado_pkg::*;
(
    input  logic [3:0] valor,
    input  logic       modo_hex,
    input  logic       apagar,
    output logic [0:6] segmentos
);

    logic [0:6] hex_ou_branco;

    always_comb begin
        hex_ou_branco = SEG_APAGADO;
        segmentos     = SEG_APAGADO;
        unique case (valor)
            4'hA: hex_ou_branco = G_A;
            4'hB: hex_ou_branco = G_B;
            4'hC: hex_ou_branco = G_C;
            4'hD: hex_ou_branco = G_D;
            4'hE: hex_ou_branco = G_E;
            4'hF: hex_ou_branco = G_F;
            default: hex_ou_branco = SEG_APAGADO;
        endcase
        if (!apagar) begin
            unique case (valor)
                4'h0: segmentos = G_0;
                4'h1: segmentos = G_1;
                4'h2: segmentos = G_2;
                4'h3: segmentos = G_3;
                4'h4: segmentos = G_4;
                4'h5: segmentos = G_5;
                4'h6: segmentos = G_6;
                4'h7: segmentos = G_7;
                4'h8: segmentos = G_8;
                4'h9: segmentos = G_9;
                default: segmentos = modo_hex ? hex_ou_branco : SEG_APAGADO;
            endcase
        end
    end

endmodule

// File: rtl/display_multiplexado.sv
// N-digit time-multiplexed 7-segment driver with blanking gap, double buffer,
// leading-zero suppression and decimal points. Ports: clock, reset (sync, high),
// valores/pontos/carregar (load), apagar_zeros, segmentos/ponto/anodos (active-low), indice.
module display_multiplexado
    import display_multiplexado_pkg::*;
#(
    parameter int N_DIGITOS     = 4,
    parameter int DIV_VARREDURA = 50000,
    parameter int T_APAGADO     = 2,
    parameter int MODO_HEX      = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [4*N_DIGITOS-1:0]       valores,
    input  logic [N_DIGITOS-1:0]         pontos,
    input  logic                         carregar,
    input  logic                         apagar_zeros,
    output logic [0:6]                   segmentos,
    output logic                         ponto,
    output logic [N_DIGITOS-1:0]         anodos,
    output logic [$clog2(N_DIGITOS)-1:0] indice
);

    localparam int TA   = (T_APAGADO > 0) ? T_APAGADO : 1;
    localparam int CMAX = (DIV_VARREDURA > TA) ? DIV_VARREDURA : TA;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(N_DIGITOS);
    localparam int BW   = 4 * N_DIGITOS;

    estado_t              estado, estado_prox;
    logic [CW-1:0]        cnt, cnt_prox;
    logic [IW-1:0]        idx, idx_prox, idx_seguinte;
    logic                 fim_exibe, fim_apag, avanca, wrap;

    logic [BW-1:0]        ativo_v, pend_v;
    logic [N_DIGITOS-1:0] ativo_p, pend_p;
    logic                 pendente;

    logic [3:0]           digito;
    logic                 ponto_sel, todos_zero, suprime;
    logic [0:6]           glifo;

    assign fim_exibe = (estado == EXIBE) && (cnt == CW'(DIV_VARREDURA - 1));
    assign fim_apag  = (estado == APAGADO) && (cnt == CW'(TA - 1));
    // With no gap the digit advances straight out of EXIBE.
    assign avanca    = fim_apag || ((T_APAGADO == 0) && fim_exibe);
    assign wrap      = avanca && (idx == IW'(N_DIGITOS - 1));

    assign idx_seguinte = (idx == IW'(N_DIGITOS - 1)) ? '0 : idx + 1'b1;
    assign indice       = idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= EXIBE;
            cnt    <= '0;
            idx    <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
            idx    <= idx_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt + 1'b1;
        idx_prox    = idx;
        unique case (estado)
            EXIBE: begin
                if (fim_exibe) begin
                    cnt_prox = '0;
                    if (T_APAGADO == 0) begin
                        idx_prox = idx_seguinte;
                    end else begin
                        estado_prox = APAGADO;
                    end
                end
            end
            APAGADO: begin
                if (fim_apag) begin
                    cnt_prox    = '0;
                    estado_prox = EXIBE;
                    idx_prox    = idx_seguinte;
                end
            end
            default: estado_prox = EXIBE;
        endcase
    end

    // Active buffer only moves on the frame wrap, so a frame is never torn.
    always_ff @(posedge clock) begin
        if (reset) begin
            ativo_v  <= '0;
            ativo_p  <= '0;
            pend_v   <= '0;
            pend_p   <= '0;
            pendente <= 1'b0;
        end else if (wrap && carregar) begin
            ativo_v  <= valores;
            ativo_p  <= pontos;
            pendente <= 1'b0;
        end else if (wrap && pendente) begin
            ativo_v  <= pend_v;
            ativo_p  <= pend_p;
            pendente <= 1'b0;
        end else if (carregar) begin
            pend_v   <= valores;
            pend_p   <= pontos;
            pendente <= 1'b1;
        end
    end

    // Digit mux plus "everything from here upward is zero" detection.
    always_comb begin
        digito     = '0;
        ponto_sel  = 1'b0;
        todos_zero = 1'b1;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (idx == IW'(i)) begin
                digito    = ativo_v[4*i +: 4];
                ponto_sel = ativo_p[i];
            end
            if ((i >= int'(idx)) && (ativo_v[4*i +: 4] != 4'd0)) begin
                todos_zero = 1'b0;
            end
        end
        suprime = apagar_zeros && (idx != '0) && todos_zero;
    end

    decodificador_hex u_dec (
        .valor     (digito),
        .modo_hex  (MODO_HEX != 0),
        .apagar    (suprime),
        .segmentos (glifo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            segmentos <= SEG_APAGADO;
            ponto     <= 1'b1;
            anodos    <= '1;
        end else if (estado == EXIBE) begin
            segmentos <= glifo;
            ponto     <= ~ponto_sel;
            anodos    <= ~(N_DIGITOS'(1) << idx);
        end else begin
            segmentos <= SEG_APAGADO;
            ponto     <= 1'b1;
            anodos    <= '1;
        end
    end

endmodule
